// File: rtl/vga_scanout.sv
// vga_scanout: display-side reader of the double-buffered framebuffer.
// Generates VGA raster timing from the system clock through a pixel-clock
// enable, issues prefetched framebuffer read addresses, and maps the returned
// 4-bit colour index through a writable 16-entry palette to RGB444.
//
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   addr_vga            framebuffer read address (prefetched one pixel ahead)
//   data_vga            colour index, valid one clock after addr_vga
//   pal_we/addr/data    palette write port, {r,g,b} nibbles
//   vga_r/g/b           registered pixel colour
//   vga_hsync/vsync     registered active-low syncs
//   vga_de              high while a visible pixel is being output
//   frame_start         one-clock pulse when the counters wrap to (0,0)
module vga_scanout #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned FB_WIDTH    = 320,
    parameter int unsigned SCALE_SHIFT = 1
) (
    input  logic        clock,
    input  logic        reset,
    output logic [18:0] addr_vga,
    input  logic [3:0]  data_vga,
    input  logic        pal_we,
    input  logic [3:0]  pal_addr,
    input  logic [11:0] pal_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_de,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW         = $clog2(H_TOTAL);
    localparam int unsigned VW         = $clog2(V_TOTAL);
    localparam int unsigned DW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned AW         = 19;
    localparam int unsigned HS_START   = H_ACTIVE + H_FP;
    localparam int unsigned HS_END     = HS_START + H_SYNC;
    localparam int unsigned VS_START   = V_ACTIVE + V_FP;
    localparam int unsigned VS_END     = VS_START + V_SYNC;
    localparam int unsigned SCALE_MASK = (1 << SCALE_SHIFT) - 1;

    logic [DW-1:0] div;
    logic [HW-1:0] h_count;
    logic [VW-1:0] v_count;
    logic [AW-1:0] line_base;
    logic [11:0]   palette [16];

    logic          tick_c;
    logic          h_last_c;
    logic          v_last_c;
    logic [HW-1:0] h_next_c;
    logic [VW-1:0] v_next_c;
    logic          cur_vis_c;
    logic          next_vis_c;
    logic          in_hs_c;
    logic          in_vs_c;
    logic [AW-1:0] base_next_c;
    logic [AW-1:0] addr_next_c;

    // Pixel-clock enable divider.
    assign tick_c = (div == DW'(CLK_DIV - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div <= '0;
        end else if (tick_c) begin
            div <= '0;
        end else begin
            div <= div + DW'(1);
        end
    end

    // Successor position, visibility, sync windows and prefetch address.
    always_comb begin
        h_last_c    = (h_count == HW'(H_TOTAL - 1));
        v_last_c    = (v_count == VW'(V_TOTAL - 1));
        h_next_c    = h_count + HW'(1);
        v_next_c    = v_count;
        base_next_c = line_base;
        if (h_last_c) begin
            h_next_c = '0;
            if (v_last_c) begin
                v_next_c    = '0;
                base_next_c = '0;
            end else begin
                v_next_c = v_count + VW'(1);
                // Move to the next framebuffer row once every replicated line group is done.
                if ((v_count < VW'(V_ACTIVE)) &&
                    ((v_count & VW'(SCALE_MASK)) == VW'(SCALE_MASK))) begin
                    base_next_c = line_base + AW'(FB_WIDTH);
                end
            end
        end
        cur_vis_c   = (h_count < HW'(H_ACTIVE)) && (v_count < VW'(V_ACTIVE));
        next_vis_c  = (h_next_c < HW'(H_ACTIVE)) && (v_next_c < VW'(V_ACTIVE));
        in_hs_c     = (h_count >= HW'(HS_START)) && (h_count < HW'(HS_END));
        in_vs_c     = (v_count >= VW'(VS_START)) && (v_count < VW'(VS_END));
        addr_next_c = base_next_c + AW'(h_next_c >> SCALE_SHIFT);
    end

    // Raster counters, line base and registered pixel outputs, all tick-gated.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_count   <= '0;
            v_count   <= '0;
            line_base <= '0;
            addr_vga  <= '0;
            vga_r     <= '0;
            vga_g     <= '0;
            vga_b     <= '0;
            vga_de    <= 1'b0;
            vga_hsync <= 1'b1;
            vga_vsync <= 1'b1;
        end else if (tick_c) begin
            h_count   <= h_next_c;
            v_count   <= v_next_c;
            line_base <= base_next_c;
            // Address for the next pixel goes out now so its data is back by the next tick.
            if (next_vis_c) begin
                addr_vga <= addr_next_c;
            end
            vga_de    <= cur_vis_c;
            vga_hsync <= ~in_hs_c;
            vga_vsync <= ~in_vs_c;
            if (cur_vis_c) begin
                {vga_r, vga_g, vga_b} <= palette[data_vga];
            end else begin
                {vga_r, vga_g, vga_b} <= 12'h000;
            end
        end
    end

    // Frame wrap pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= tick_c && h_last_c && v_last_c;
        end
    end

    // Palette: grey ramp at reset, writable at any time.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                palette[i] <= {4'(i), 4'(i), 4'(i)};
            end
        end else if (pal_we) begin
            palette[pal_addr] <= pal_data;
        end
    end

endmodule
